tcp_conn_table: RTL and testbench

Multi-connection TCP server control engine. It holds a table of NUM_CONN passive-open connection slots and runs the SYN / SYN-ACK / ACK handshake for each slot independently. It also retransmits SYN-ACK on timeout and handles RST, FIN and forced disconnect. It sits between the RX header parser and the TX segment builder, and replaces the single-connection server control path.

---
 rtl/tcp_conn_table_pkg.sv | 58 +++++
 rtl/tcp_conn_timer.sv | 51 +++++
 rtl/tcp_conn_table.sv | 263 ++++++++++++++++++++++++++
 tb/tb_tcp_conn_table.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_conn_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcp_conn_pkg
// Purpose  : Shared types and helpers for the multi-slot TCP server engine.
// Revision : 1.0 - initial release
// ============================================================================
package tcp_conn_pkg;

    localparam int c_max_conn = 16;

    // Flag nibble order: {syn, ackf, fin, rstf}
    localparam logic [3:0] c_f_syn_ack = 4'b1100;
    localparam logic [3:0] c_f_rst_ack = 4'b0101;
    localparam logic [3:0] c_f_rst     = 4'b0001;
    localparam logic [3:0] c_f_fin_ack = 4'b0110;

    typedef enum logic [1:0] {
        FREE        = 2'd0,
        SYN_RCVD    = 2'd1,
        ESTABLISHED = 2'd2
    } conn_state_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq;
        logic [31:0] ack;
        logic        syn;
        logic        ackf;
        logic        fin;
        logic        rstf;
    } tcp_hdr_t;

    typedef struct packed {
        conn_state_t state;
        logic [15:0] remote_port;
        logic [31:0] local_seq;
        logic [31:0] local_ack;
    } slot_t;

    function automatic tcp_hdr_t mk_hdr(
        input logic [15:0] src,
        input logic [15:0] dst,
        input logic [31:0] seq,
        input logic [31:0] ack,
        input logic [3:0]  flags
    );
        tcp_hdr_t h;
        h.src_port = src;
        h.dst_port = dst;
        h.seq      = seq;
        h.ack      = ack;
        {h.syn, h.ackf, h.fin, h.rstf} = flags;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcp_conn_timer.sv
`default_nettype none
// ============================================================================
// Module   : tcp_conn_timer
// Purpose  : Per-slot SYN-ACK retransmit timer and retry counter.
// Revision : 1.0 - initial release
// ============================================================================
module tcp_conn_timer #(
    parameter int SYN_TIMEOUT = 1024,
    parameter int MAX_RETRY   = 3
)(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    input  logic active,
    input  logic served,
    output logic expire,
    output logic abandon
);

    localparam int TW = $clog2(SYN_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_retry;
    logic          r_pending;
    logic          w_hit;

    // Timer freezes while a retransmit is pending so expiry fires only once
    assign w_hit   = active && !r_pending && (r_timer == TW'(SYN_TIMEOUT - 1));
    assign abandon = w_hit && (r_retry == RW'(MAX_RETRY));
    assign expire  = r_pending;

    always_ff @(posedge clk) begin
        if (rst || clear || start) begin
            r_timer   <= '0;
            r_retry   <= '0;
            r_pending <= 1'b0;
        end else if (served) begin
            r_timer   <= '0;
            r_retry   <= r_retry + 1'b1;
            r_pending <= 1'b0;
        end else if (w_hit) begin
            r_pending <= !abandon;
        end else if (active && !r_pending) begin
            r_timer   <= r_timer + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcp_conn_table.sv
`default_nettype none
// ============================================================================
// Module   : tcp_conn_table
// Purpose  : Multi-slot passive-open TCP handshake / teardown control engine.
// Revision : 1.0 - initial release
// ============================================================================
module tcp_conn_table
    import tcp_conn_pkg::*;
#(
    parameter int          NUM_CONN    = 4,
    parameter logic [31:0] ISN_BASE    = 32'h7D0,
    parameter int          SYN_TIMEOUT = 1024,
    parameter int          MAX_RETRY   = 3,
    localparam int         ID_W        = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                listen_en,
    input  logic [15:0]         local_port,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic [15:0]         rx_src_port,
    input  logic [15:0]         rx_dst_port,
    input  logic [31:0]         rx_seq,
    input  logic [31:0]         rx_ack,
    input  logic                rx_syn,
    input  logic                rx_ackf,
    input  logic                rx_fin,
    input  logic                rx_rst,
    input  logic                dcn_valid,
    output logic                dcn_ready,
    input  logic [ID_W-1:0]     dcn_id,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [15:0]         tx_src_port,
    output logic [15:0]         tx_dst_port,
    output logic [31:0]         tx_seq,
    output logic [31:0]         tx_ack,
    output logic                tx_syn,
    output logic                tx_ackf,
    output logic                tx_fin,
    output logic                tx_rst,
    output logic [ID_W-1:0]     tx_conn_id,
    output logic [NUM_CONN-1:0] est_mask,
    output logic [15:0]         drop_cnt
);

    localparam int PAD_N = 1 << ID_W;

    slot_t               r_slot     [NUM_CONN];
    slot_t               w_slot_nxt [NUM_CONN];
    tcp_hdr_t            r_tx;
    tcp_hdr_t            w_tx_nxt;
    logic [ID_W-1:0]     r_tx_id;
    logic [ID_W-1:0]     w_tx_id_nxt;
    logic                r_tx_valid;
    logic                w_tx_load;
    logic [NUM_CONN-1:0] r_est_mask;
    logic [15:0]         r_drop_cnt;
    logic                w_drop_inc;

    logic                w_rx_hs;
    logic                w_dcn_hs;
    logic                w_match_any;
    logic [ID_W-1:0]     w_match_idx;
    logic                w_free_any;
    logic [ID_W-1:0]     w_free_idx;
    logic                w_pend_any;
    logic [ID_W-1:0]     w_pend_idx;
    logic [NUM_CONN-1:0] w_busy;
    logic [PAD_N-1:0]    w_busy_pad;
    logic [NUM_CONN-1:0] w_start;
    logic [NUM_CONN-1:0] w_serve;
    logic [NUM_CONN-1:0] w_clear;
    logic [NUM_CONN-1:0] w_active;
    logic [NUM_CONN-1:0] w_expire;
    logic [NUM_CONN-1:0] w_abandon;
    slot_t               w_ms;
    slot_t               w_ds;
    slot_t               w_ps;

    assign rx_ready  = !r_tx_valid && !rst;
    assign dcn_ready = !r_tx_valid && !rx_valid && !rst;
    assign w_rx_hs   = rx_valid && rx_ready;
    assign w_dcn_hs  = dcn_valid && dcn_ready;

    // Out-of-range dcn_id (non power-of-two table) reads as a FREE slot
    assign w_busy_pad = PAD_N'(w_busy);

    assign w_ms = r_slot[w_match_idx];
    assign w_ds = r_slot[dcn_id];
    assign w_ps = r_slot[w_pend_idx];

    // Descending scans leave the lowest qualifying index in each result
    always_comb begin
        w_match_any = 1'b0;
        w_match_idx = '0;
        w_free_any  = 1'b0;
        w_free_idx  = '0;
        w_pend_any  = 1'b0;
        w_pend_idx  = '0;
        w_busy      = '0;
        for (int i = NUM_CONN - 1; i >= 0; i--) begin
            w_busy[i] = (r_slot[i].state != FREE);
            if (w_busy[i] && r_slot[i].remote_port == rx_src_port) begin
                w_match_any = 1'b1;
                w_match_idx = ID_W'(i);
            end
            if (!w_busy[i]) begin
                w_free_any = 1'b1;
                w_free_idx = ID_W'(i);
            end
            if (w_expire[i]) begin
                w_pend_any = 1'b1;
                w_pend_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_slot_nxt  = r_slot;
        w_start     = '0;
        w_serve     = '0;
        w_tx_load   = 1'b0;
        w_tx_nxt    = '0;
        w_tx_id_nxt = '0;
        w_drop_inc  = 1'b0;
        for (int i = 0; i < NUM_CONN; i++) begin
            if (w_abandon[i]) begin
                w_slot_nxt[i].state = FREE;
            end
        end
        if (w_rx_hs) begin
            if (rx_dst_port != local_port) begin
                w_drop_inc = 1'b1;
            end else if (w_match_any && rx_rst) begin
                w_slot_nxt[w_match_idx].state = FREE;
            end else if (!w_match_any && rx_syn && !rx_ackf && listen_en) begin
                w_tx_load = 1'b1;
                if (w_free_any) begin
                    w_slot_nxt[w_free_idx].state       = SYN_RCVD;
                    w_slot_nxt[w_free_idx].remote_port = rx_src_port;
                    w_slot_nxt[w_free_idx].local_seq   = ISN_BASE + 32'(w_free_idx);
                    w_slot_nxt[w_free_idx].local_ack   = rx_seq + 32'd1;
                    w_start[w_free_idx] = 1'b1;
                    w_tx_nxt    = mk_hdr(local_port, rx_src_port, ISN_BASE + 32'(w_free_idx),
                                         rx_seq + 32'd1, c_f_syn_ack);
                    w_tx_id_nxt = w_free_idx;
                end else begin
                    w_tx_nxt   = mk_hdr(local_port, rx_src_port, 32'd0, rx_seq + 32'd1, c_f_rst_ack);
                    w_drop_inc = 1'b1;
                end
            end else if (w_match_any && w_ms.state == SYN_RCVD) begin
                if (rx_ackf && rx_ack == w_ms.local_seq + 32'd1) begin
                    w_slot_nxt[w_match_idx].local_seq = w_ms.local_seq + 32'd1;
                    w_slot_nxt[w_match_idx].state     = ESTABLISHED;
                end else begin
                    w_slot_nxt[w_match_idx].state = FREE;
                    w_tx_load   = 1'b1;
                    w_tx_nxt    = mk_hdr(local_port, rx_src_port, rx_ack, 32'd0, c_f_rst);
                    w_tx_id_nxt = w_match_idx;
                end
            end else if (w_match_any && w_ms.state == ESTABLISHED) begin
                if (rx_fin) begin
                    w_slot_nxt[w_match_idx].state = FREE;
                    w_tx_load   = 1'b1;
                    w_tx_nxt    = mk_hdr(local_port, rx_src_port, w_ms.local_seq,
                                         rx_seq + 32'd1, c_f_fin_ack);
                    w_tx_id_nxt = w_match_idx;
                end else begin
                    w_slot_nxt[w_match_idx].local_ack = rx_ack;
                end
            end else begin
                w_drop_inc = 1'b1;
            end
        end else if (w_dcn_hs) begin
            if (w_busy_pad[dcn_id]) begin
                w_slot_nxt[dcn_id].state = FREE;
                w_tx_load   = 1'b1;
                w_tx_nxt    = mk_hdr(local_port, w_ds.remote_port, w_ds.local_seq,
                                     w_ds.local_ack, c_f_rst_ack);
                w_tx_id_nxt = dcn_id;
            end
        end else if (!r_tx_valid && w_pend_any) begin
            w_serve[w_pend_idx] = 1'b1;
            w_tx_load   = 1'b1;
            w_tx_nxt    = mk_hdr(local_port, w_ps.remote_port, w_ps.local_seq,
                                 w_ps.local_ack, c_f_syn_ack);
            w_tx_id_nxt = w_pend_idx;
        end
    end

    // Leaving SYN_RCVD for any reason cancels that slot's timer and pending resend
    always_comb begin
        w_clear  = '0;
        w_active = '0;
        for (int i = 0; i < NUM_CONN; i++) begin
            w_clear[i]  = (w_slot_nxt[i].state != SYN_RCVD);
            w_active[i] = (r_slot[i].state == SYN_RCVD);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CONN; gi++) begin : g_timer
            tcp_conn_timer #(
                .SYN_TIMEOUT (SYN_TIMEOUT),
                .MAX_RETRY   (MAX_RETRY)
            ) u_timer (
                .clk     (clk),
                .rst     (rst),
                .start   (w_start[gi]),
                .clear   (w_clear[gi]),
                .active  (w_active[gi]),
                .served  (w_serve[gi]),
                .expire  (w_expire[gi]),
                .abandon (w_abandon[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONN; i++) begin
                r_slot[i] <= '0;
            end
            r_tx       <= '0;
            r_tx_id    <= '0;
            r_tx_valid <= 1'b0;
            r_est_mask <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CONN; i++) begin
                r_slot[i]     <= w_slot_nxt[i];
                r_est_mask[i] <= (w_slot_nxt[i].state == ESTABLISHED);
            end
            if (w_tx_load) begin
                r_tx       <= w_tx_nxt;
                r_tx_id    <= w_tx_id_nxt;
                r_tx_valid <= 1'b1;
            end else if (r_tx_valid && tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            if (w_drop_inc && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign tx_valid    = r_tx_valid;
    assign tx_src_port = r_tx.src_port;
    assign tx_dst_port = r_tx.dst_port;
    assign tx_seq      = r_tx.seq;
    assign tx_ack      = r_tx.ack;
    assign tx_syn      = r_tx.syn;
    assign tx_ackf     = r_tx.ackf;
    assign tx_fin      = r_tx.fin;
    assign tx_rst      = r_tx.rstf;
    assign tx_conn_id  = r_tx_id;
    assign est_mask    = r_est_mask;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tcp_conn_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcp_conn_table
// Purpose  : Directed scoreboard bench for tcp_conn_table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcp_conn_table;

    localparam int          NUM_CONN    = 4;
    localparam int          SYN_TIMEOUT = 32;
    localparam int          MAX_RETRY   = 3;
    localparam logic [15:0] LPORT       = 16'd80;
    localparam logic [3:0]  F_NONE      = 4'b0000;
    localparam logic [3:0]  F_SYN       = 4'b1000;
    localparam logic [3:0]  F_ACK       = 4'b0100;
    localparam logic [3:0]  F_FINACK    = 4'b0110;
    localparam logic [3:0]  F_RST       = 4'b0001;
    localparam logic [3:0]  F_SYNACK    = 4'b1100;
    localparam logic [3:0]  F_RSTACK    = 4'b0101;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [3:0]  flags;
        logic [1:0]  id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        listen_en = 1'b1;
    logic [15:0] local_port = LPORT;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] rx_src_port = '0;
    logic [15:0] rx_dst_port = '0;
    logic [31:0] rx_seq = '0;
    logic [31:0] rx_ack = '0;
    logic        rx_syn = 1'b0, rx_ackf = 1'b0, rx_fin = 1'b0, rx_rst = 1'b0;
    logic        dcn_valid = 1'b0;
    logic        dcn_ready;
    logic [1:0]  dcn_id = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] tx_src_port, tx_dst_port;
    logic [31:0] tx_seq, tx_ack;
    logic        tx_syn, tx_ackf, tx_fin, tx_rst;
    logic [1:0]  tx_conn_id;
    logic [3:0]  est_mask;
    logic [15:0] drop_cnt;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    tcp_conn_table #(
        .NUM_CONN    (NUM_CONN),
        .ISN_BASE    (32'h7D0),
        .SYN_TIMEOUT (SYN_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .listen_en   (listen_en),
        .local_port  (local_port),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_src_port (rx_src_port),
        .rx_dst_port (rx_dst_port),
        .rx_seq      (rx_seq),
        .rx_ack      (rx_ack),
        .rx_syn      (rx_syn),
        .rx_ackf     (rx_ackf),
        .rx_fin      (rx_fin),
        .rx_rst      (rx_rst),
        .dcn_valid   (dcn_valid),
        .dcn_ready   (dcn_ready),
        .dcn_id      (dcn_id),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_src_port (tx_src_port),
        .tx_dst_port (tx_dst_port),
        .tx_seq      (tx_seq),
        .tx_ack      (tx_ack),
        .tx_syn      (tx_syn),
        .tx_ackf     (tx_ackf),
        .tx_fin      (tx_fin),
        .tx_rst      (tx_rst),
        .tx_conn_id  (tx_conn_id),
        .est_mask    (est_mask),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] dst, input logic [31:0] seq,
                                input logic [31:0] ack, input logic [3:0] f, input logic [1:0] id);
        exp_t e;
        e.src = LPORT; e.dst = dst; e.seq = seq; e.ack = ack; e.flags = f; e.id = id;
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each negedge with tx_valid && tx_ready precedes exactly one output handshake
    always @(negedge clk) begin
        exp_t obs;
        exp_t e;
        if (!rst && tx_valid && tx_ready) begin
            obs = {tx_src_port, tx_dst_port, tx_seq, tx_ack, tx_syn, tx_ackf, tx_fin, tx_rst, tx_conn_id};
            n_chk++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL tx_unexpected observed=%h expected=none", obs);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("tx_segment", 128'(obs), 128'(e));
            end
        end
    end

    task automatic rx_send(input logic [15:0] src, input logic [15:0] dst,
                           input logic [31:0] seq, input logic [31:0] ack, input logic [3:0] f);
        int n = 0;
        @(negedge clk);
        rx_src_port = src; rx_dst_port = dst; rx_seq = seq; rx_ack = ack;
        {rx_syn, rx_ackf, rx_fin, rx_rst} = f;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        assert (n < 100) else begin
            n_fail++;
            $error("FAIL rx_timeout observed=%0d expected=<100", n);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic dcn_send(input logic [1:0] id);
        int n = 0;
        @(negedge clk);
        dcn_id = id;
        dcn_valid = 1'b1;
        while (!dcn_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        assert (n < 100) else begin
            n_fail++;
            $error("FAIL dcn_timeout observed=%0d expected=<100", n);
        end
        @(posedge clk);
        #1;
        dcn_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while ((sb.size() != 0 || tx_valid) && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        assert (n < bound) else begin
            n_fail++;
            $error("FAIL %s drain_timeout observed=%0d pending=%0d expected=0", tag, n, sb.size());
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {tx_valid, rx_ready, dcn_ready, est_mask, drop_cnt}, '0);
        check("reset_tx", {tx_src_port, tx_dst_port, tx_seq, tx_ack, tx_syn, tx_ackf, tx_fin, tx_rst, tx_conn_id}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Handshake on slot 0
        sb.push_back(mk(16'd5000, 32'h7D0, 32'd101, F_SYNACK, 2'd0));
        rx_send(16'd5000, LPORT, 32'd100, 32'd0, F_SYN);
        check("synack_latency", tx_valid, 1'b1);
        wait_drain("handshake", 20);
        rx_send(16'd5000, LPORT, 32'd101, 32'h7D1, F_ACK);
        check("ack_no_tx", tx_valid, 1'b0);
        check("est_after_ack", est_mask, 4'b0001);

        // Sequence wrap on slot 1
        sb.push_back(mk(16'd6000, 32'h7D1, 32'h0, F_SYNACK, 2'd1));
        rx_send(16'd6000, LPORT, 32'hFFFF_FFFF, 32'd0, F_SYN);
        wait_drain("wrap", 20);
        rx_send(16'd6000, LPORT, 32'd0, 32'h7D2, F_ACK);
        check("est_wrap", est_mask, 4'b0011);

        // Fill the table, then overflow
        sb.push_back(mk(16'd7000, 32'h7D2, 32'd11, F_SYNACK, 2'd2));
        rx_send(16'd7000, LPORT, 32'd10, 32'd0, F_SYN);
        wait_drain("fill2", 20);
        rx_send(16'd7000, LPORT, 32'd11, 32'h7D3, F_ACK);
        sb.push_back(mk(16'd7001, 32'h7D3, 32'd21, F_SYNACK, 2'd3));
        rx_send(16'd7001, LPORT, 32'd20, 32'd0, F_SYN);
        wait_drain("fill3", 20);
        rx_send(16'd7001, LPORT, 32'd21, 32'h7D4, F_ACK);
        check("est_full", est_mask, 4'b1111);
        sb.push_back(mk(16'd7002, 32'd0, 32'd8, F_RSTACK, 2'd0));
        rx_send(16'd7002, LPORT, 32'd7, 32'd0, F_SYN);
        check("full_drop", {est_mask, drop_cnt}, {4'b1111, 16'd1});
        wait_drain("full", 20);

        // FIN with backpressure and a competing disconnect request
        @(negedge clk);
        tx_ready = 1'b0;
        rx_src_port = 16'd7000; rx_dst_port = LPORT; rx_seq = 32'd500; rx_ack = 32'h7D3;
        {rx_syn, rx_ackf, rx_fin, rx_rst} = F_FINACK;
        rx_valid = 1'b1;
        dcn_id = 2'd3;
        dcn_valid = 1'b1;
        #1;
        check("rx_over_dcn", {rx_ready, dcn_ready}, 2'b10);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("est_after_fin", est_mask, 4'b1011);
        repeat (10) begin
            @(negedge clk);
            check("tx_hold", {tx_valid, tx_seq, tx_ack, tx_fin, tx_ackf, tx_conn_id, rx_ready, dcn_ready},
                  {1'b1, 32'h7D3, 32'd501, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0});
        end
        sb.push_back(mk(16'd7000, 32'h7D3, 32'd501, F_FINACK, 2'd2));
        sb.push_back(mk(16'd7001, 32'h7D4, 32'd21, F_RSTACK, 2'd3));
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        begin
            int n = 0;
            while (!dcn_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("dcn_accept", dcn_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        dcn_valid = 1'b0;
        check("est_after_dcn", est_mask, 4'b0011);
        wait_drain("teardown", 20);

        // Disconnect of a free slot, wrong port, SYN while not listening
        dcn_send(2'd2);
        check("dcn_free_no_tx", {tx_valid, est_mask}, {1'b0, 4'b0011});
        rx_send(16'd8000, 16'd81, 32'd1, 32'd0, F_SYN);
        check("drop_port", drop_cnt, 16'd2);
        listen_en = 1'b0;
        rx_send(16'd8001, LPORT, 32'd1, 32'd0, F_SYN);
        check("drop_nolisten", {drop_cnt, tx_valid}, {16'd3, 1'b0});
        listen_en = 1'b1;

        // RST frees slots, then retransmit sequence on slot 0
        rx_send(16'd5000, LPORT, 32'd0, 32'd0, F_RST);
        rx_send(16'd6000, LPORT, 32'd0, 32'd0, F_RST);
        check("est_after_rst", {est_mask, tx_valid}, {4'b0000, 1'b0});
        repeat (1 + MAX_RETRY) sb.push_back(mk(16'd9000, 32'h7D0, 32'd1001, F_SYNACK, 2'd0));
        rx_send(16'd9000, LPORT, 32'd1000, 32'd0, F_SYN);
        wait_drain("retransmit", 8 * SYN_TIMEOUT);
        repeat (2 * SYN_TIMEOUT) @(negedge clk);
        sb.push_back(mk(16'd9100, 32'h7D0, 32'd51, F_SYNACK, 2'd0));
        rx_send(16'd9100, LPORT, 32'd50, 32'd0, F_SYN);
        wait_drain("reuse", 20);

        // Reset while a segment is held
        @(negedge clk);
        tx_ready = 1'b0;
        rx_send(16'd9200, LPORT, 32'd5, 32'd0, F_SYN);
        check("held_before_rst", {tx_valid, tx_conn_id}, {1'b1, 2'd1});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ctrl", {tx_valid, rx_ready, dcn_ready, est_mask, drop_cnt}, '0);
        check("rst_tx", {tx_src_port, tx_dst_port, tx_seq, tx_ack, tx_syn, tx_ackf, tx_fin, tx_rst, tx_conn_id}, '0);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        sb.push_back(mk(16'd9300, 32'h7D0, 32'd3, F_SYNACK, 2'd0));
        rx_send(16'd9300, LPORT, 32'd2, 32'd0, F_SYN);
        wait_drain("post_rst", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
